// File: rtl/ddr3_ctrl_pkg.sv
// Shared definitions for the DDR3 fill write/read controllers: FSM encoding and
// fill-header field positions.
package ddr3_ctrl_pkg;

    localparam int S_IDLE  = 0;
    localparam int S_LOAD  = 1;
    localparam int S_ISSUE = 2;
    localparam int S_DRAIN = 3;
    localparam int S_DONE  = 4;
    localparam int S_ERR   = 5;
    localparam int NUM_ST  = 6;

    typedef enum logic [NUM_ST-1:0] {
        ST_IDLE  = NUM_ST'(1 << S_IDLE),
        ST_LOAD  = NUM_ST'(1 << S_LOAD),
        ST_ISSUE = NUM_ST'(1 << S_ISSUE),
        ST_DRAIN = NUM_ST'(1 << S_DRAIN),
        ST_DONE  = NUM_ST'(1 << S_DONE),
        ST_ERR   = NUM_ST'(1 << S_ERR)
    } rd_state_t;

    localparam int START_ADDR_MSB = 75;
    localparam int START_ADDR_LSB = 53;
    localparam int BURST_CNT_MSB  = 22;
    localparam int BURST_CNT_LSB  = 0;
    localparam int CNT_W          = 24;

endpackage

// File: rtl/rd_credit_cntr.sv
// Outstanding read-request counter: up on accept, down on returned beat, both
// at once leaves it unchanged.
module rd_credit_cntr #(
    parameter int MAX = 16,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    input  logic dec,
    output logic below_lim,
    output logic zero
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && !dec)
            cnt_d = cnt_q + W'(1);
        else if (dec && !inc)
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign below_lim = (cnt_q < W'(MAX));
    assign zero      = (cnt_q == '0);
endmodule

// File: rtl/ddr3_rd_control.sv
// Reads completed fills back from DDR3 via the MIG user port into the readout FIFO.
// Define RD_CTRL_CHECKSUM_EN to check each fill's trailing XOR checksum burst.
module ddr3_rd_control
    import ddr3_ctrl_pkg::*;
#(
    parameter int ADDR_W       = 23,
    parameter int DATA_W       = 128,
    parameter int MAX_OUTST    = 16,
    parameter int EXTRA_BURSTS = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_enabled,
    input  logic [127:0]      fill_header_rd_dat,
    input  logic              fill_header_empty,
    output logic              fill_header_rd_en,
    output logic [ADDR_W+2:0] ddr3_rd_addr,
    output logic              rd_app_en,
    input  logic              rd_app_rdy,
    input  logic [DATA_W-1:0] app_rd_data,
    input  logic              app_rd_data_valid,
    output logic [DATA_W-1:0] rd_fifo_dat,
    output logic              rd_fifo_wr_en,
    input  logic              rd_fifo_prog_full,
    output logic              rd_busy,
    output logic              rd_done,
    output logic              rd_sync_err,
    output logic              cksum_err
);
    rd_state_t         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  req_q, req_d, beat_q, beat_d, hdr_cnt;
    logic [6:0]        win_q, win_d;
    logic [DATA_W-1:0] dat_q;
    logic              wr_q, sync_err_q;
    logic              below_lim, outst_zero, accept, beat_ok, stray;
    logic              unused_hdr;

    assign unused_hdr = ^{fill_header_rd_dat[127:START_ADDR_MSB+1],
                          fill_header_rd_dat[START_ADDR_LSB-1:BURST_CNT_MSB+1]};
    assign hdr_cnt = CNT_W'(fill_header_rd_dat[BURST_CNT_MSB:BURST_CNT_LSB]) + CNT_W'(EXTRA_BURSTS);

    assign rd_app_en = rd_enabled && (state_q == ST_ISSUE) && (req_q != '0)
                       && below_lim && !rd_fifo_prog_full;
    assign accept  = rd_app_en && rd_app_rdy;
    assign beat_ok = app_rd_data_valid && rd_enabled && !outst_zero;
    // Late beats from an aborted fill are dropped silently while the window runs.
    assign stray   = app_rd_data_valid && rd_enabled && outst_zero && (win_q == '0);

    rd_credit_cntr #(.MAX(MAX_OUTST)) u_credit (
        .clk       (clk),
        .reset     (reset),
        .clr       (!rd_enabled),
        .inc       (accept),
        .dec       (beat_ok),
        .below_lim (below_lim),
        .zero      (outst_zero)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        req_d   = req_q;
        beat_d  = beat_q;
        win_d   = (win_q != '0) ? win_q - 7'd1 : '0;
        if (accept) begin
            addr_d = addr_q + ADDR_W'(1);
            req_d  = req_q - CNT_W'(1);
        end
        if (beat_ok)
            beat_d = beat_q - CNT_W'(1);
        case (state_q)
            ST_IDLE:  if (!fill_header_empty) state_d = ST_LOAD;
            ST_LOAD: begin
                addr_d  = ADDR_W'(fill_header_rd_dat[START_ADDR_MSB:START_ADDR_LSB]);
                req_d   = hdr_cnt;
                beat_d  = hdr_cnt;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: if (req_q == '0)  state_d = ST_DRAIN;
            ST_DRAIN: if (beat_q == '0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            ST_ERR:   state_d = ST_ERR;
            default:  state_d = ST_IDLE;
        endcase
        if (stray)
            state_d = ST_ERR;
        if (!rd_enabled) begin
            state_d = ST_IDLE;
            addr_d  = '0;
            req_d   = '0;
            beat_d  = '0;
            if (state_q != ST_IDLE)
                win_d = 7'd64;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            req_q      <= '0;
            beat_q     <= '0;
            win_q      <= '0;
            dat_q      <= '0;
            wr_q       <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            beat_q  <= beat_d;
            win_q   <= win_d;
            wr_q    <= beat_ok;
            if (beat_ok) dat_q <= app_rd_data;
            if (stray)   sync_err_q <= 1'b1;
        end
    end

`ifdef RD_CTRL_CHECKSUM_EN
    logic [DATA_W-1:0] acc_q;
    logic              cks_q;

    // The final beat of a fill carries the XOR of all earlier beats.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            cks_q <= 1'b0;
        end else if (state_q == ST_LOAD) begin
            acc_q <= '0;
        end else if (beat_ok) begin
            if (beat_q == CNT_W'(1)) begin
                if (acc_q != app_rd_data) cks_q <= 1'b1;
            end else begin
                acc_q <= acc_q ^ app_rd_data;
            end
        end
    end
    assign cksum_err = cks_q;
`else
    assign cksum_err = 1'b0;
`endif

    assign fill_header_rd_en = (state_q == ST_LOAD);
    assign ddr3_rd_addr      = {addr_q, 3'b000};
    assign rd_fifo_dat       = dat_q;
    assign rd_fifo_wr_en     = wr_q;
    assign rd_busy           = (state_q != ST_IDLE);
    assign rd_done           = (state_q == ST_DONE);
    assign rd_sync_err       = sync_err_q;
endmodule

// File: tb/tb_ddr3_rd_control.sv
// Scoreboard bench for ddr3_rd_control with a queue-based header FIFO and MIG model.
module tb_ddr3_rd_control;
    logic         clk = 1'b0;
    logic         reset, rd_enabled, fill_header_empty, fill_header_rd_en;
    logic [127:0] fill_header_rd_dat, app_rd_data, rd_fifo_dat;
    logic [25:0]  ddr3_rd_addr;
    logic         rd_app_en, rd_app_rdy, app_rd_data_valid, rd_fifo_wr_en, rd_fifo_prog_full;
    logic         rd_busy, rd_done, rd_sync_err, cksum_err;

    always #5 clk = ~clk;

    ddr3_rd_control dut (
        .clk(clk), .reset(reset), .rd_enabled(rd_enabled),
        .fill_header_rd_dat(fill_header_rd_dat), .fill_header_empty(fill_header_empty),
        .fill_header_rd_en(fill_header_rd_en), .ddr3_rd_addr(ddr3_rd_addr),
        .rd_app_en(rd_app_en), .rd_app_rdy(rd_app_rdy), .app_rd_data(app_rd_data),
        .app_rd_data_valid(app_rd_data_valid), .rd_fifo_dat(rd_fifo_dat),
        .rd_fifo_wr_en(rd_fifo_wr_en), .rd_fifo_prog_full(rd_fifo_prog_full),
        .rd_busy(rd_busy), .rd_done(rd_done), .rd_sync_err(rd_sync_err), .cksum_err(cksum_err)
    );

`ifdef RD_CTRL_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    int total = 0, bad = 0;
    logic [127:0] hdr_q[$], mig_q[$], ret_dat[$], exp_q[$];
    logic [25:0]  exp_addr[$];
    int           ret_due[$];
    int  cyc = 0, lat = 5, rdy_mode = 1, outst = 0, max_outst = 0;
    int  n_acc = 0, n_wr = 0, n_done = 0, d0, a0, a1, w0;
    bit  en = 0, pf = 0, pf_rand = 0, stray = 0, hold_prev = 0;
    logic [25:0]  addr_prev;
    logic [127:0] mon_e;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] memw(input logic [22:0] a);
        logic [31:0] w;
        w = {9'd0, a};
        return {w ^ 32'hA5A5_0000, w * 32'h9E37_79B1, ~w, w + 32'h0000_1234};
    endfunction

    // Reference model: a fill of cnt+2 bursts at consecutive (wrapping) addresses,
    // last burst = XOR of the others (optionally corrupted).
    task automatic push_fill(input logic [22:0] start, input int cnt, input bit bad_ck);
        logic [127:0] x, d, h;
        logic [22:0]  a;
        x = '0;
        for (int i = 0; i < cnt + 2; i++) begin
            a = start + 23'(i);
            exp_addr.push_back({a, 3'b000});
            if (i < cnt + 1) begin
                d = memw(a);
                x ^= d;
            end else begin
                d = x ^ {127'd0, bad_ck};
            end
            mig_q.push_back(d);
            exp_q.push_back(d);
        end
        h = {$urandom, $urandom, $urandom, $urandom};
        h[75:53] = start;
        h[22:0]  = 23'(cnt);
        hdr_q.push_back(h);
    endtask

    // One clock: drive at negedge, then record what the next posedge will commit.
    task automatic step();
        logic [25:0] ea;
        @(negedge clk);
        cyc++;
        if (pf_rand) pf = ($urandom_range(7) == 0);
        fill_header_empty  = (hdr_q.size() == 0);
        fill_header_rd_dat = (hdr_q.size() != 0) ? hdr_q[0] : '0;
        rd_enabled         = en;
        rd_fifo_prog_full  = pf;
        rd_app_rdy         = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(3) != 0);
        app_rd_data_valid  = 1'b0;
        if (stray) begin
            app_rd_data_valid = 1'b1;
            app_rd_data       = {$urandom, $urandom, $urandom, $urandom};
            stray             = 0;
        end else if (ret_due.size() != 0 && ret_due[0] <= cyc) begin
            app_rd_data_valid = 1'b1;
            app_rd_data       = ret_dat.pop_front();
            void'(ret_due.pop_front());
            outst--;
        end
        #1;
        if (hold_prev && !pf && en) begin
            check("en_held", rd_app_en, 1);
            check("addr_stable", ddr3_rd_addr, addr_prev);
        end
        hold_prev = rd_app_en && !rd_app_rdy && !pf && en;
        addr_prev = ddr3_rd_addr;
        if (rd_app_en && rd_app_rdy) begin
            if (exp_addr.size() != 0) ea = exp_addr.pop_front();
            else                      ea = 'x;
            check("req_addr", ddr3_rd_addr, ea);
            ret_due.push_back(cyc + lat);
            ret_dat.push_back(mig_q.size() != 0 ? mig_q.pop_front() : '0);
            outst++;
            n_acc++;
        end
        if (outst > max_outst) max_outst = outst;
        if (fill_header_rd_en && hdr_q.size() != 0) void'(hdr_q.pop_front());
    endtask

    task automatic run_until(input int budget);
        int n = 0;
        while (n < budget && (exp_q.size() != 0 || hdr_q.size() != 0 || rd_busy || ret_due.size() != 0)) begin
            step();
            n++;
        end
        check("pending_beats", exp_q.size(), 0);
        check("idle_busy", rd_busy, 0);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (rd_fifo_wr_en) begin
                if (exp_q.size() != 0) mon_e = exp_q.pop_front();
                else                   mon_e = 'x;
                check("beat", rd_fifo_dat, mon_e);
                n_wr++;
            end
            if (rd_done) n_done++;
        end
    end

    initial begin
        reset = 1'b1; rd_enabled = 1'b0; fill_header_empty = 1'b1; fill_header_rd_dat = '0;
        rd_app_rdy = 1'b0; app_rd_data = '0; app_rd_data_valid = 1'b0; rd_fifo_prog_full = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {rd_busy, rd_app_en, fill_header_rd_en, rd_fifo_wr_en, rd_done, rd_sync_err, cksum_err}, 0);
        check("rst_addr", ddr3_rd_addr, 0);
        check("rst_dat", rd_fifo_dat, 0);
        reset = 1'b0;
        en = 1;

        // basic fill, 5 bursts at 0x800..0x820
        lat = 5; d0 = n_done; a0 = n_acc;
        push_fill(23'h000100, 3, 1'b0);
        run_until(200);
        check("t1_done", n_done - d0, 1);
        check("t1_reqs", n_acc - a0, 5);

        // MIG not ready for 10 cycles mid-fill
        lat = 8; d0 = n_done;
        push_fill(23'h002000, 20, 1'b0);
        repeat (8) step();
        a1 = n_acc; rdy_mode = 0;
        repeat (10) step();
        check("t2_no_acc", n_acc - a1, 0);
        rdy_mode = 1;
        run_until(400);
        check("t2_done", n_done - d0, 1);

        // long latency: credit limit must saturate at 16
        lat = 40; max_outst = 0; d0 = n_done;
        push_fill(23'h010000, 30, 1'b0);
        run_until(1000);
        check("t3_max_outst", max_outst, 16);
        check("t3_done", n_done - d0, 1);

        // prog_full after 4 requests
        lat = 10; d0 = n_done; a0 = n_acc; w0 = n_wr;
        push_fill(23'h020000, 10, 1'b0);
        for (int i = 0; i < 50 && n_acc - a0 < 4; i++) step();
        pf = 1;
        repeat (30) step();
        check("t4_reqs", n_acc - a0, 4);
        check("t4_beats", n_wr - w0, 4);
        pf = 0;
        run_until(300);
        check("t4_done", n_done - d0, 1);
        check("t4_cksum_ok", cksum_err, 0);

        // address wrap, bad checksum when checking is built in
        lat = 3; d0 = n_done;
        push_fill(23'h7FFFFE, 1, CK);
        run_until(100);
        check("t5_done", n_done - d0, 1);
        check("t5_cksum", cksum_err, CK);

        // randomized fills with random ready, latency and prog_full
        rdy_mode = 2; pf_rand = 1; lat = $urandom_range(30, 1); d0 = n_done;
        for (int i = 0; i < 6; i++) push_fill(23'($urandom), $urandom_range(12), 1'b0);
        run_until(3000);
        pf_rand = 0; pf = 0; rdy_mode = 1;
        check("t6_done", n_done - d0, 6);

        // abort mid-fill: late beats dropped, no sync error
        lat = 20; a0 = n_acc;
        push_fill(23'h030000, 20, 1'b0);
        for (int i = 0; i < 60 && n_acc - a0 < 6; i++) step();
        en = 0;
        repeat (3) step();
        exp_q.delete(); mig_q.delete(); exp_addr.delete();
        check("abort_idle", rd_busy, 0);
        en = 1;
        repeat (60) step();
        check("abort_no_err", rd_sync_err, 0);
        d0 = n_done;
        push_fill(23'h040000, 2, 1'b0);
        run_until(200);
        check("abort_recover", n_done - d0, 1);
        repeat (70) step();

        // stray beat in IDLE
        w0 = n_wr;
        stray = 1;
        repeat (5) step();
        check("stray_err", rd_sync_err, 1);
        check("stray_err_state", rd_busy, 1);
        repeat (5) step();
        check("err_hold", rd_busy, 1);
        check("stray_no_wr", n_wr - w0, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst2_err", {rd_sync_err, cksum_err, rd_busy}, 0);
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
